// File: rtl/rr_bus_arbiter.sv
// rtl/rr_bus_arbiter.sv - 8-way round-robin bus arbiter with shared data mux
// Optional burst lock with a 16-transfer hold limit: define ARB_LOCK_EN.
module rr_bus_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         req,
    input  logic [8*WIDTH-1:0] data,
    input  logic [7:0]         lock,
    input  logic               out_ready,
    output logic [7:0]         grant,
    output logic [2:0]         sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] base;
    logic [2:0] pick;
    logic       transfer;
    logic       hold;

    // During a transfer the scan starts at sel+1, which is also the new ptr.
    always_comb begin
        base = (state == BUSY) ? sel + 3'd1 : ptr;
        pick = base;
        for (int k = 7; k >= 0; k--) begin
            if (req[base + k[2:0]]) begin
                pick = base + k[2:0];
            end
        end
    end

    assign transfer = (state == BUSY) && out_ready;

`ifdef ARB_LOCK_EN
    logic [3:0] hold_cnt;

    assign hold = transfer && lock[sel] && req[sel] && (hold_cnt != 4'hF);
`else
    logic unused_lock;

    assign unused_lock = ^lock;
    assign hold        = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            grant     <= 8'd0;
            sel       <= 3'd0;
            out_valid <= 1'b0;
`ifdef ARB_LOCK_EN
            hold_cnt  <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req != 8'd0) begin
                        sel       <= pick;
                        grant     <= 8'd1 << pick;
                        out_valid <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (transfer) begin
                        if (hold) begin
`ifdef ARB_LOCK_EN
                            hold_cnt <= hold_cnt + 4'd1;
`endif
                        end else begin
`ifdef ARB_LOCK_EN
                            hold_cnt <= 4'd0;
`endif
                            ptr <= sel + 3'd1;
                            if (req != 8'd0) begin
                                sel   <= pick;
                                grant <= 8'd1 << pick;
                            end else begin
                                grant     <= 8'd0;
                                out_valid <= 1'b0;
                                state     <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_data = out_valid ? data[sel*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb/tb_rr_bus_arbiter.sv - vector table, lock corner sequence and random check of rr_bus_arbiter
module tb_rr_bus_arbiter;
    localparam int W = 16;
`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic [7:0]     req;
    logic [7:0]     lock;
    logic [8*W-1:0] data;
    logic           out_ready;
    logic [7:0]     grant;
    logic [2:0]     sel;
    logic [W-1:0]   out_data;
    logic           out_valid;

    rr_bus_arbiter #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .req(req), .data(data), .lock(lock),
        .out_ready(out_ready), .grant(grant), .sel(sel), .out_data(out_data),
        .out_valid(out_valid)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;

    // Reference model: a "busy" flag, the served index, the pointer and a lock run length.
    bit m_busy = 0;
    int m_sel  = 0;
    int m_ptr  = 0;
    int m_hold = 0;

    function automatic int first_from(int p, logic [7:0] r);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return 0;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_busy = 0; m_sel = 0; m_ptr = 0; m_hold = 0;
        end else if (!m_busy) begin
            if (req != 8'd0) begin
                m_sel  = first_from(m_ptr, req);
                m_busy = 1;
            end
        end else if (out_ready) begin
            if (LOCK_EN && lock[m_sel] && req[m_sel] && m_hold < 15) begin
                m_hold = m_hold + 1;
            end else begin
                m_hold = 0;
                m_ptr  = (m_sel + 1) % 8;
                if (req != 8'd0) m_sel = first_from(m_ptr, req);
                else m_busy = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic check(string name, bit ev, int es, logic [W-1:0] ed);
        logic [7:0] eg;
        eg = ev ? (8'd1 << es) : 8'd0;
        vectors++;
        if (grant !== eg || sel !== es[2:0] || out_valid !== ev || out_data !== ed) begin
            errors++;
            $display("FAIL %s: got grant=%h sel=%0d valid=%b data=%h, want grant=%h sel=%0d valid=%b data=%h",
                     name, grant, sel, out_valid, out_data, eg, es, ev, ed);
        end
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] rq;
        bit         rdy;
        bit         ev;
        int         es;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rst, logic [7:0] rq, bit rdy, bit ev, int es);
        vec_t v;
        v.rst = rst; v.rq = rq; v.rdy = rdy; v.ev = ev; v.es = es;
        tbl.push_back(v);
    endfunction

    initial begin
        reset = 1'b1; req = 8'd0; lock = 8'd0; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) data[i*W +: W] = W'(i);

        add(1, 8'h00, 1, 0, 0);
        add(1, 8'h00, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 8'hFF, 1, 1, i % 8);
        add(1, 8'h00, 1, 0, 0);
        add(0, 8'h22, 1, 1, 1);
        add(0, 8'h22, 1, 1, 5);
        add(0, 8'h22, 1, 1, 1);
        add(0, 8'h22, 1, 1, 5);
        for (int i = 0; i < 3; i++) add(0, 8'h22, 0, 1, 5);
        add(0, 8'h00, 1, 0, 5);
        add(0, 8'h08, 0, 1, 3);
        add(0, 8'h08, 0, 1, 3);
        add(1, 8'h08, 0, 0, 0);
        add(0, 8'h08, 0, 1, 3);
        add(0, 8'h0A, 1, 1, 1);
        add(0, 8'h0A, 1, 1, 3);

        foreach (tbl[i]) begin
            reset = tbl[i].rst; req = tbl[i].rq; out_ready = tbl[i].rdy;
            step();
            check($sformatf("table[%0d]", i), tbl[i].ev, tbl[i].es,
                  tbl[i].ev ? W'(tbl[i].es) : '0);
        end

        // Burst lock on requester 2 competing with requester 3.
        reset = 1'b1; req = 8'h00; lock = 8'h00;
        step();
        reset = 1'b0; req = 8'h0C; lock = 8'h04; out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            int es;
            if (LOCK_EN) es = (i < 16) ? 2 : ((i == 16) ? 3 : 2);
            else         es = (i % 2 == 0) ? 2 : 3;
            step();
            check($sformatf("lock[%0d]", i), 1'b1, es, W'(es));
        end

        reset = 1'b1; req = 8'h00; lock = 8'h00;
        step();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            req   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom & $urandom);
            if (m_busy && $urandom_range(0, 9) != 0) req[m_sel] = 1'b1;
            lock      = $urandom_range(0, 1) ? 8'hFF : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) data[i*W +: W] = W'($urandom);
            step();
            check($sformatf("random[%0d]", n), m_busy, m_sel,
                  m_busy ? data[m_sel*W +: W] : '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
